// File: rtl/array_shift_pkg.sv
// Shared definitions for the array shift unit: operation encoding, FSM states
// and the width helpers used to size ports from the array geometry.
package array_shift_pkg;

    typedef enum logic {
        SHIFT_UP   = 1'b0,
        SHIFT_DOWN = 1'b1
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        READ,
        WRITE,
        RDPOS,
        CAPTURE,
        INSERT,
        DONE
    } state_t;

    // Array-select width; a single array still gets one select bit.
    function automatic int array_width(input int n_arrays);
        return (n_arrays > 1) ? $clog2(n_arrays) : 1;
    endfunction

    function automatic int index_width(input int n_area);
        return $clog2(n_area) + 1;
    endfunction

    function automatic int heap_width(input int n_arrays, input int n_area);
        return array_width(n_arrays) + $clog2(n_area);
    endfunction

endpackage

// File: rtl/array_size_table.sv
// Per-array element counts with one arbitrated write port (FSM update wins over
// an external resize, which is honoured only while idle) and two read ports.
module array_size_table #(
    parameter int NArrays = 2,
    parameter int AW      = 1,
    parameter int IW      = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          busy,
    input  logic          upd_en,
    input  logic [AW-1:0] upd_array,
    input  logic [IW-1:0] upd_size,
    input  logic          resize_en,
    input  logic [AW-1:0] resize_array,
    input  logic [IW-1:0] resize_size,
    input  logic [AW-1:0] check_array,
    output logic [IW-1:0] check_size,
    input  logic [AW-1:0] query_array,
    output logic [IW-1:0] query_size
);

    logic          wr_en;
    logic [AW-1:0] wr_array;
    logic [IW-1:0] wr_size;
    logic [IW-1:0] sizes [NArrays];

    always_comb begin
        wr_en    = 1'b0;
        wr_array = '0;
        wr_size  = '0;
        if (upd_en) begin
            wr_en    = 1'b1;
            wr_array = upd_array;
            wr_size  = upd_size;
        end else if (resize_en && !busy) begin
            wr_en    = 1'b1;
            wr_array = resize_array;
            wr_size  = resize_size;
        end
    end

    generate
        for (genvar gi = 0; gi < NArrays; gi++) begin : g_entry
            logic [IW-1:0] size_reg;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    size_reg <= '0;
                end else if (wr_en && (wr_array == AW'(gi))) begin
                    size_reg <= wr_size;
                end
            end

            assign sizes[gi] = size_reg;
        end
    endgenerate

    assign check_size = sizes[check_array];
    assign query_size = sizes[query_array];

endmodule

// File: rtl/array_shift_unit.sv
// Insert-with-shift-up / delete-with-shift-down engine over arrays held in an
// external single-port heap RAM with one-cycle read latency.
module array_shift_unit
    import array_shift_pkg::*;
#(
    parameter int MemoryElementWidth = 12,
    parameter int NArea              = 4,
    parameter int NArrays            = 2,
    localparam int AW = array_width(NArrays),
    localparam int IW = index_width(NArea),
    localparam int HW = heap_width(NArrays, NArea)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          op,
    input  logic [AW-1:0]                 array,
    input  logic [IW-1:0]                 pos,
    input  logic [MemoryElementWidth-1:0] value,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [MemoryElementWidth-1:0] result,
    output logic [HW-1:0]                 mem_addr,
    output logic                          mem_wr,
    output logic [MemoryElementWidth-1:0] mem_wdata,
    input  logic [MemoryElementWidth-1:0] mem_rdata,
    input  logic                          resize_en,
    input  logic [AW-1:0]                 resize_array,
    input  logic [IW-1:0]                 resize_value,
    input  logic [AW-1:0]                 query_array,
    output logic [IW-1:0]                 query_size
);

    state_t                        state_reg;
    op_t                           op_reg;
    logic [AW-1:0]                 array_reg;
    logic [IW-1:0]                 pos_reg;
    logic [IW-1:0]                 size_reg;
    logic [IW-1:0]                 idx_reg;
    logic [MemoryElementWidth-1:0] value_reg;
    logic [MemoryElementWidth-1:0] result_reg;
    logic                          busy_reg;
    logic                          done_reg;
    logic                          error_reg;

    logic [IW-1:0] check_size;
    logic          upd_en;
    logic [IW-1:0] upd_size;
    logic [IW-2:0] slot;

    // The size table is committed during DONE so the next request sees it.
    assign upd_en   = (state_reg == DONE) && !error_reg;
    assign upd_size = (op_reg == SHIFT_UP) ? size_reg + 1'b1 : size_reg - 1'b1;

    array_size_table #(
        .NArrays (NArrays),
        .AW      (AW),
        .IW      (IW)
    ) u_size_table (
        .clock        (clock),
        .reset        (reset),
        .busy         (busy_reg),
        .upd_en       (upd_en),
        .upd_array    (array_reg),
        .upd_size     (upd_size),
        .resize_en    (resize_en),
        .resize_array (resize_array),
        .resize_size  (resize_value),
        .check_array  (array_reg),
        .check_size   (check_size),
        .query_array  (query_array),
        .query_size   (query_size)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            op_reg     <= SHIFT_UP;
            array_reg  <= '0;
            pos_reg    <= '0;
            size_reg   <= '0;
            idx_reg    <= '0;
            value_reg  <= '0;
            result_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_reg    <= op_t'(op);
                        array_reg <= array;
                        pos_reg   <= pos;
                        value_reg <= value;
                        busy_reg  <= 1'b1;
                        state_reg <= CHECK;
                    end
                end
                CHECK: begin
                    size_reg <= check_size;
                    if (op_reg == SHIFT_UP) begin
                        if ((check_size == IW'(NArea)) || (pos_reg > check_size)) begin
                            error_reg <= 1'b1;
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else if (pos_reg == check_size) begin
                            state_reg <= INSERT;
                        end else begin
                            idx_reg   <= check_size - 1'b1;
                            state_reg <= READ;
                        end
                    end else begin
                        if ((check_size == '0) || (pos_reg >= check_size)) begin
                            error_reg <= 1'b1;
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            idx_reg   <= pos_reg + 1'b1;
                            state_reg <= RDPOS;
                        end
                    end
                end
                READ: state_reg <= WRITE;
                WRITE: begin
                    if (op_reg == SHIFT_UP) begin
                        if (idx_reg == pos_reg) begin
                            state_reg <= INSERT;
                        end else begin
                            idx_reg   <= idx_reg - 1'b1;
                            state_reg <= READ;
                        end
                    end else if (idx_reg == size_reg - 1'b1) begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        idx_reg   <= idx_reg + 1'b1;
                        state_reg <= READ;
                    end
                end
                RDPOS: state_reg <= CAPTURE;
                CAPTURE: begin
                    result_reg <= mem_rdata;
                    // Deleting the top element needs no moves.
                    if (idx_reg == size_reg) begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        state_reg <= READ;
                    end
                end
                INSERT: begin
                    done_reg  <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    error_reg <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        slot      = '0;
        case (state_reg)
            READ: begin
                slot     = (IW-1)'(idx_reg);
                mem_addr = {array_reg, slot};
            end
            WRITE: begin
                slot      = (op_reg == SHIFT_UP) ? (IW-1)'(idx_reg + 1'b1)
                                                 : (IW-1)'(idx_reg - 1'b1);
                mem_addr  = {array_reg, slot};
                mem_wr    = 1'b1;
                mem_wdata = mem_rdata;
            end
            RDPOS: begin
                slot     = (IW-1)'(pos_reg);
                mem_addr = {array_reg, slot};
            end
            INSERT: begin
                slot      = (IW-1)'(pos_reg);
                mem_addr  = {array_reg, slot};
                mem_wr    = 1'b1;
                mem_wdata = value_reg;
            end
            default: ;
        endcase
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign error  = error_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_array_shift_unit.sv
// Directed bench for array_shift_unit with a behavioural 1-cycle-latency heap RAM.
module tb_array_shift_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic        array = 1'b0;
    logic [2:0]  pos = '0;
    logic [11:0] value = '0;
    logic        busy, done, error;
    logic [11:0] result;
    logic [2:0]  mem_addr;
    logic        mem_wr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic        resize_en = 1'b0;
    logic        resize_array = 1'b0;
    logic [2:0]  resize_value = '0;
    logic        query_array = 1'b0;
    logic [2:0]  query_size;

    logic [11:0] heap [8];
    logic        pl_en = 1'b0;
    logic [2:0]  pl_addr = '0;
    logic [11:0] pl_data = '0;

    int checks = 0;
    int errors = 0;

    array_shift_unit dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .array        (array),
        .pos          (pos),
        .value        (value),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .result       (result),
        .mem_addr     (mem_addr),
        .mem_wr       (mem_wr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .resize_en    (resize_en),
        .resize_array (resize_array),
        .resize_value (resize_value),
        .query_array  (query_array),
        .query_size   (query_size)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (pl_en) heap[pl_addr] <= pl_data;
        else if (mem_wr) heap[mem_addr] <= mem_wdata;
        mem_rdata <= heap[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [2:0] a, input logic [11:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clock); #1 pl_en = 1'b0;
    endtask

    task automatic set_size(input logic a, input logic [2:0] s);
        resize_en = 1'b1; resize_array = a; resize_value = s;
        @(posedge clock); #1 resize_en = 1'b0;
    endtask

    task automatic get_size(input logic a, output int s);
        query_array = a;
        #1 s = int'(query_size);
    endtask

    // Issues one request; cycle numbers count from the accepting edge (cycle 0).
    // inj > 0 pulses start and resize_en during that cycle of the operation.
    task automatic run_op(input logic o, input logic a, input logic [2:0] p,
                          input logic [11:0] v, input int inj,
                          output int dcyc, output logic derr, output int wrs);
        start = 1'b1; op = o; array = a; pos = p; value = v;
        @(posedge clock); #1 start = 1'b0;
        dcyc = -1; derr = 1'b0; wrs = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (inj > 0 && c == inj) begin
                start = 1'b1; op = 1'b0; array = 1'b0; pos = 3'd0; value = 12'd55;
                resize_en = 1'b1; resize_array = 1'b0; resize_value = 3'd3;
            end
            if (inj > 0 && c == inj + 1) begin
                start = 1'b0; resize_en = 1'b0;
            end
            if (mem_wr) wrs++;
            if (done) begin
                dcyc = c; derr = error;
                break;
            end
        end
        @(posedge clock); #1;
        $display("op=%0d array=%0d pos=%0d value=%0d -> done_cycle=%0d error=%0d result=%0d writes=%0d",
                 o, a, p, v, dcyc, derr, result, wrs);
    endtask

    task automatic load_array1_012();
        preload(3'd4, 12'd0);
        preload(3'd5, 12'd1);
        preload(3'd6, 12'd2);
        set_size(1'b1, 3'd3);
    endtask

    int          dcyc, wrs, sz;
    logic        derr;

    initial begin
        for (int i = 0; i < 8; i++) heap[i] = '0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_memwr", mem_wr, 0);
        check("reset_result", result, 0);
        @(posedge clock); @(posedge clock); #1 reset = 1'b1;
        get_size(1'b0, sz); check("reset_size0", sz, 0);
        get_size(1'b1, sz); check("reset_size1", sz, 0);

        // Insert at the bottom of [0,1,2].
        load_array1_012();
        get_size(1'b1, sz); check("resize_size1", sz, 3);
        run_op(1'b0, 1'b1, 3'd0, 12'd99, 0, dcyc, derr, wrs);
        check("up0_done_cycle", dcyc, 9);
        check("up0_error", derr, 0);
        check("up0_heap", {heap[4], heap[5], heap[6], heap[7]}, {12'd99, 12'd0, 12'd1, 12'd2});
        get_size(1'b1, sz); check("up0_size", sz, 4);

        // Full array rejects insert.
        run_op(1'b0, 1'b1, 3'd1, 12'd5, 0, dcyc, derr, wrs);
        check("upfull_done_cycle", dcyc, 2);
        check("upfull_error", derr, 1);
        check("upfull_writes", wrs, 0);
        get_size(1'b1, sz); check("upfull_size", sz, 4);

        // Delete position 1 of [99,0,1,2]; top slot is left as-is.
        run_op(1'b1, 1'b1, 3'd1, 12'd0, 0, dcyc, derr, wrs);
        check("down1_done_cycle", dcyc, 8);
        check("down1_error", derr, 0);
        check("down1_result", result, 0);
        check("down1_heap", {heap[4], heap[5], heap[6], heap[7]}, {12'd99, 12'd1, 12'd2, 12'd2});
        get_size(1'b1, sz); check("down1_size", sz, 3);

        // Empty array 0: append, out-of-range delete, delete last.
        run_op(1'b0, 1'b0, 3'd0, 12'd7, 0, dcyc, derr, wrs);
        check("append_done_cycle", dcyc, 3);
        check("append_heap0", heap[0], 7);
        get_size(1'b0, sz); check("append_size", sz, 1);
        run_op(1'b1, 1'b0, 3'd1, 12'd0, 0, dcyc, derr, wrs);
        check("downbad_error", derr, 1);
        check("downbad_done_cycle", dcyc, 2);
        run_op(1'b1, 1'b0, 3'd0, 12'd0, 0, dcyc, derr, wrs);
        check("downlast_done_cycle", dcyc, 4);
        check("downlast_result", result, 7);
        get_size(1'b0, sz); check("downlast_size", sz, 0);

        // Reset in cycle 3 of a shiftUp.
        load_array1_012();
        start = 1'b1; op = 1'b0; array = 1'b1; pos = 3'd0; value = 12'd50;
        @(posedge clock); #1 start = 1'b0;
        repeat (3) @(negedge clock);
        check("midop_busy", busy, 1);
        check("midop_memwr", mem_wr, 1);
        reset = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_memwr", mem_wr, 0);
        get_size(1'b1, sz); check("rst_size1", sz, 0);
        get_size(1'b0, sz); check("rst_size0", sz, 0);
        $display("reset asserted mid-operation");
        @(posedge clock); #1 reset = 1'b1;

        load_array1_012();
        run_op(1'b0, 1'b1, 3'd0, 12'd99, 0, dcyc, derr, wrs);
        check("postrst_done_cycle", dcyc, 9);
        check("postrst_heap", {heap[4], heap[5], heap[6], heap[7]}, {12'd99, 12'd0, 12'd1, 12'd2});
        get_size(1'b1, sz); check("postrst_size", sz, 4);

        // start and resize pulsed while busy must both be ignored.
        load_array1_012();
        run_op(1'b0, 1'b1, 3'd0, 12'd99, 4, dcyc, derr, wrs);
        check("inj_done_cycle", dcyc, 9);
        check("inj_error", derr, 0);
        check("inj_heap", {heap[4], heap[5], heap[6], heap[7]}, {12'd99, 12'd0, 12'd1, 12'd2});
        get_size(1'b1, sz); check("inj_size1", sz, 4);
        repeat (3) @(posedge clock);
        #1;
        check("inj_idle_busy", busy, 0);
        check("inj_heap0", heap[0], 7);
        get_size(1'b0, sz); check("inj_size0", sz, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/array_shift_unit.md
# array_shift_unit

Synthesizable, parametrised replacement for the single-cycle, loop-based shiftUp used in the Zero FPGA test harnesses. It performs insert-with-shift-up and delete-with-shift-down at any position of a heap array. Arrays live in an external single-port synchronous heap RAM, one element per cycle pair. The unit owns the per-array size table and sits between the Zero instruction sequencer and heap memory.

## Interface
- MemoryElementWidth, 12, width of a heap element and of value/result
- NArea, 4, elements per array area; power of two, at least 2
- NArrays, 2, number of arrays; power of two
- Derived: AW = clog2(NArrays), IW = clog2(NArea)+1 (index/size width), HW = AW+clog2(NArea) (heap address width)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  request; accepted only in IDLE
- op  in  1  0 = shiftUp (insert), 1 = shiftDown (delete)
- array  in  AW  target array
- pos  in  IW  element position
- value  in  MemoryElementWidth  value inserted by shiftUp
- busy  out  1  high from the cycle after acceptance until DONE inclusive
- done  out  1  one-cycle pulse at completion
- error  out  1  valid with done; request rejected, nothing changed
- result  out  MemoryElementWidth  element removed by shiftDown; held until next acceptance
- mem_addr  out  HW  heap address, equal to array*NArea + index
- mem_wr  out  1  write strobe
- mem_wdata  out  MemoryElementWidth  write data
- mem_rdata  in  MemoryElementWidth  valid one cycle after a read address (mem_wr=0)
- resize_en, resize_array (AW), resize_value (IW)  in  direct size write, honoured only when not busy
- query_array  in  AW;  query_size  out  IW  combinational size lookup

## Operation
- States: IDLE, CHECK, READ, WRITE, RDPOS, CAPTURE, INSERT, DONE.
- IDLE: when start=1, latch op, array, pos and value, then go to CHECK.
- CHECK: latch size s = sizes[array].
  - shiftUp is an error if s == NArea or pos > s.
  - shiftDown is an error if s == 0 or pos >= s.
  - On error, go to DONE with error=1.
- shiftUp, k = s - pos moves:
  - Cursor i starts at s-1 and runs down to pos.
  - READ drives addr(i) with mem_wr=0.
  - WRITE drives addr(i+1) with mem_wr=1 and wdata=mem_rdata, then decrements i.
  - After the last move go to INSERT, which writes value to addr(pos). Then go to DONE and set sizes[array] = s+1.
- shiftDown, k = s - pos - 1 moves:
  - RDPOS reads addr(pos).
  - CAPTURE latches mem_rdata into result.
  - Cursor i then runs from pos+1 up to s-1: READ addr(i), then WRITE addr(i-1).
  - Go to DONE and set sizes[array] = s-1.
- Removed slot: the vacated top element, addr(s-1), is not cleared.
- DONE: pulse done, return to IDLE.
- Outside READ/WRITE/RDPOS/INSERT: mem_wr=0, mem_addr=0, mem_wdata=0.
- Arithmetic: addresses are formed by concatenation {array, i[IW-2:0]}. Size updates cannot overflow because of the CHECK rules.
- Resize: resize_en while busy is ignored entirely; no queueing. start and resize_en in the same IDLE cycle: resize is applied and start is accepted, and CHECK sees the new size.
- start while busy is ignored.
- Reset, including mid-operation: FSM to IDLE, all sizes to 0, result 0, all outputs 0. Heap contents are whatever had already been written.

## Timing
- Cycle 0 is the edge that accepts start.
- CHECK occurs in cycle 1.
- Error: done and error are high in cycle 2; no memory access occurs.
- shiftUp: READ/WRITE pairs occupy cycles 2..2k+1, INSERT is cycle 2k+2, done is cycle 2k+3.
  - Append (pos == s) therefore completes in 3 cycles.
- shiftDown: RDPOS is cycle 2, CAPTURE is cycle 3, pairs occupy cycles 4..2k+3, done is cycle 2k+4.
- result is valid from cycle 4.
- The new size is visible on query_size in the cycle after done.
- The next start can be accepted in the cycle after done.

## Structure
- Shared package array_shift_pkg holds the op encoding (SHIFT_UP=0, SHIFT_DOWN=1), the state enum, and the derived-width functions.
- Sub-module array_size_table holds:
  - NArrays x IW registers with async active-low clear;
  - one write port, arbitrated as resize or FSM update;
  - one combinational read for CHECK and one for query.
- The bench models heap RAM as a behavioural array with 1-cycle read latency.

## Test plan
- Preload array 1 = [0,1,2] with size 3, then shiftUp pos=0 value=99 -> heap[4..7] = [99,0,1,2], size 4, done at cycle 9, error=0.
- Array 1 now full (size 4), shiftUp pos=1 -> error=1 at cycle 2, no mem_wr in any cycle, size stays 4.
- On [99,0,1,2], shiftDown pos=1 -> result=0, heap[4..6] = [99,1,2], size 3, done at cycle 8.
- Array 0 empty:
  - shiftUp pos=0 value=7 -> heap[0]=7, size 1, done at cycle 3;
  - then shiftDown pos=1 -> error=1;
  - then shiftDown pos=0 -> result=7, size 0, done at cycle 4.
- Assert reset in cycle 3 of a shiftUp on [0,1,2]:
  - busy, done and mem_wr drop immediately and all sizes read 0;
  - a new request after release executes normally.
- Pulse start during a busy operation and resize_en while busy -> both ignored; the completing operation's result and size match the uninterrupted case.
